dma_sched: RTL and testbench
============================

DMA_SCHED -- requirements
Module: dma_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4096, meaning consecutive no-beat cycles in RUN before the operation is aborted.
REQ-002 SHALL have parameter BEAT_W, default 16, meaning width of the beat counter.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous assert, active-low, synchronous release.
REQ-005 SHALL have ports ch0_req/ch1_req  input  1  requester holds high to request one operation.
REQ-006 SHALL have ports ch0_dc/ch1_dc  input  24  descriptor control word per requester; bit 4 selects copy.
REQ-007 SHALL have ports ch0_ack/ch1_ack  output  1  one-cycle grant pulse.
REQ-008 SHALL have ports ch0_done/ch1_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports ch0_err/ch1_err  output  1  valid only with matching done; 1 = illegal descriptor or timeout.
REQ-010 SHALL have port dc  output  24  control word to copy datapath.
REQ-011 SHALL have port eng_rst  output  1  active-high reset to copy datapath.
REQ-012 SHALL have port m_endn  input  1  datapath end indication, active-low.
REQ-013 SHALL have port m_dst_putn  input  1  datapath beat strobe, active-low.
REQ-014 SHALL have ports beat_cnt  output  BEAT_W; busy  output  1; owner  output  1 (0=ch0, 1=ch1).

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, CLEAR, DONE; busy = (state != IDLE).
REQ-016 IDLE: with one req high SHALL grant it; with both high SHALL grant the channel not granted last (round-robin pointer, ch0 first after reset).
REQ-017 On grant SHALL latch chX_dc into dc, set owner, pulse chX_ack in the following cycle.
REQ-018 Grant with latched dc[4]=0 SHALL go IDLE->DONE directly with err=1, eng_rst held 1, dc forced 0.
REQ-019 Grant with dc[4]=1 SHALL go IDLE->LOAD; LOAD SHALL drive eng_rst=0, clear beat_cnt and idle counter, go RUN next cycle.
REQ-020 RUN: every cycle with m_dst_putn=0 SHALL increment beat_cnt (saturating at all-ones) and clear idle counter; otherwise increment idle counter.
REQ-021 RUN: m_endn=0 sampled SHALL go CLEAR with err=0.
REQ-022 RUN: idle counter reaching TIMEOUT-1 with m_endn=1 SHALL go CLEAR with err=1; simultaneous m_endn=0 and timeout SHALL count as success.
REQ-023 m_endn and m_dst_putn SHALL be ignored outside RUN (undriven when dc[4]=0).
REQ-024 CLEAR SHALL last exactly one cycle with eng_rst=1, dc=0, then DONE.
REQ-025 DONE SHALL pulse owner's chX_done (and chX_err if flagged) one cycle, update round-robin pointer to owner, go IDLE.
REQ-026 beat_cnt SHALL hold its final value from CLEAR until next LOAD.
REQ-027 eng_rst SHALL be 1 in IDLE, CLEAR, DONE; 0 in LOAD, RUN.
REQ-028 Requester deasserting req after ack SHALL NOT abort the operation; requester SHALL drop req in its done cycle, else re-arbitration treats it as new request.
REQ-029 Non-owner req SHALL wait, unacknowledged, until IDLE.

Reset
REQ-030 wb_rst_i=0 SHALL immediately force state IDLE, dc=0, eng_rst=1, all ack/done/err=0, beat_cnt=0, owner=0, busy=0, pointer=ch0, including mid-RUN.
REQ-031 After release, first grant SHALL occur no earlier than the first rising edge with wb_rst_i=1.

Verification
REQ-032 ch0_req with dc=24'h000010, datapath puts 8 beats then m_endn=0 -> ch0_ack once, eng_rst 0 during RUN, ch0_done 2 cycles after m_endn sampled, err=0, beat_cnt=8.
REQ-033 ch0 and ch1 req together, both held -> ch0 served first, then ch1, then ch0; no overlapping busy windows.
REQ-034 ch1_dc=24'h000000 -> ch1_ack then ch1_done with ch1_err=1, eng_rst never 0, beat_cnt unchanged.
REQ-035 TIMEOUT=16 build, 3 beats then stall -> done with err=1 exactly 16 cycles after last beat path, eng_rst pulses 1, beat_cnt=3.
REQ-036 wb_rst_i=0 mid-RUN after 5 beats -> same cycle dc=0, eng_rst=1, busy=0; no done pulse emitted.

Source files
------------

// File: rtl/dma_sched_if.sv
// Requester-side handshake for one DMA channel: request with its descriptor,
// grant/completion pulses and the error flag that accompanies completion.
interface dma_sched_if;
  logic        req;
  logic [23:0] dc;
  logic        ack;
  logic        done;
  logic        err;

  modport master (output req, dc, input ack, done, err);
  modport slave  (input req, dc, output ack, done, err);
endinterface

// File: rtl/dma_sched.sv
// Two-channel round-robin scheduler that owns a single copy datapath: grants one
// request at a time, runs it with a no-beat watchdog and reports done/err.
//
// state | meaning
// IDLE  | datapath held in reset, arbitrating requests
// LOAD  | descriptor presented, engine released, counters cleared
// RUN   | counting beats, watching for end or idle timeout
// CLEAR | one-cycle engine reset after the operation
// DONE  | completion pulse to the owner, priority handed over
module dma_sched #(
  parameter logic [15:0] TIMEOUT = 16'd4096,
  parameter int unsigned BEAT_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  dma_sched_if.slave        ch0,
  dma_sched_if.slave        ch1,
  output logic [23:0]       dc,
  output logic              eng_rst,
  input  logic              m_endn,
  input  logic              m_dst_putn,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] IDLE_LAST = TIMEOUT - 16'd1;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] dc_q;
  logic [23:0] grant_dc;
  logic [15:0] idle_cnt;
  logic        prio;
  logic        err_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        grant_vld;
  logic        grant_ch;
  logic        run_err;
  logic        engine_on;

  assign grant_dc = grant_ch ? ch1.dc : ch0.dc;

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_ch  = prio;
    run_err   = 1'b0;
    case (state)
      IDLE: begin
        if (ch0.req || ch1.req) begin
          grant_vld = 1'b1;
          grant_ch  = (ch0.req && ch1.req) ? prio : ch1.req;
          state_nxt = grant_dc[4] ? LOAD : DONE;
        end
      end
      LOAD:  state_nxt = RUN;
      RUN: begin
        // an end seen in the timeout cycle still counts as a clean finish
        if (!m_endn) begin
          state_nxt = CLEAR;
        end else if (m_dst_putn && (idle_cnt == 16'd0)) begin
          state_nxt = CLEAR;
          run_err   = 1'b1;
        end
      end
      CLEAR: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= IDLE;
      dc_q     <= '0;
      owner    <= 1'b0;
      prio     <= 1'b0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ack0_q <= grant_vld && !grant_ch;
      ack1_q <= grant_vld && grant_ch;
      if (grant_vld) begin
        owner <= grant_ch;
        dc_q  <= grant_dc;
        err_q <= !grant_dc[4];
      end else if ((state == RUN) && (state_nxt == CLEAR)) begin
        err_q <= run_err;
      end
      // idle watchdog is a down-counter; zero on a no-beat cycle is the abort
      if (state == LOAD) begin
        beat_cnt <= '0;
        idle_cnt <= IDLE_LAST;
      end else if (state == RUN) begin
        if (!m_dst_putn) begin
          if (beat_cnt != {BEAT_W{1'b1}}) beat_cnt <= beat_cnt + BEAT_W'(1);
          idle_cnt <= IDLE_LAST;
        end else if (idle_cnt != 16'd0) begin
          idle_cnt <= idle_cnt - 16'd1;
        end
      end
      if (state == DONE) prio <= ~owner;
    end
  end

  assign engine_on = (state == LOAD) || (state == RUN);
  assign eng_rst   = ~engine_on;
  assign dc        = engine_on ? dc_q : 24'h000000;
  assign busy      = (state != IDLE);

  assign ch0.ack  = ack0_q;
  assign ch1.ack  = ack1_q;
  assign ch0.done = (state == DONE) && !owner;
  assign ch1.done = (state == DONE) && owner;
  assign ch0.err  = ch0.done && err_q;
  assign ch1.err  = ch1.done && err_q;

endmodule

// File: tb/tb_dma_sched.sv
// Directed bench for dma_sched: legal copy, illegal descriptor, round-robin,
// idle timeout and its tie with end, beat saturation, and reset mid-operation.
module tb_dma_sched;
  localparam int BW = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [23:0]   dc;
  logic          eng_rst;
  logic          m_endn;
  logic          m_dst_putn;
  logic [BW-1:0] beat_cnt;
  logic          busy;
  logic          owner;

  int n_cmp = 0;
  int n_bad = 0;

  dma_sched_if ch0();
  dma_sched_if ch1();

  dma_sched #(.TIMEOUT(16'd16), .BEAT_W(BW)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .ch0        (ch0),
    .ch1        (ch1),
    .dc         (dc),
    .eng_rst    (eng_rst),
    .m_endn     (m_endn),
    .m_dst_putn (m_dst_putn),
    .beat_cnt   (beat_cnt),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // called in a RUN cycle; returns in the DONE cycle
  task automatic end_op();
    m_endn = 1'b0;
    cyc();
    m_endn = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_rst_i   = 1'b0;
    m_endn     = 1'b1;
    m_dst_putn = 1'b1;
    ch0.req = 1'b1; ch0.dc = 24'h000010;
    ch1.req = 1'b0; ch1.dc = 24'h000000;
    cyc(2);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_eng_rst", 32'(eng_rst),  32'd1);
    chk("rst_dc",      32'(dc),       32'd0);
    chk("rst_beat",    32'(beat_cnt), 32'd0);
    chk("rst_ack",     32'(ch0.ack),  32'd0);
    chk("rst_owner",   32'(owner),    32'd0);

    // legal copy on ch0, 8 beats then end
    wb_rst_i = 1'b1;
    cyc();
    chk("t1_ack",      32'(ch0.ack), 32'd1);
    chk("t1_busy",     32'(busy),    32'd1);
    chk("t1_dc",       32'(dc),      32'h000010);
    chk("t1_eng_load", 32'(eng_rst), 32'd0);
    chk("t1_owner",    32'(owner),   32'd0);
    ch0.req = 1'b0;
    cyc();
    chk("t1_ack_pulse", 32'(ch0.ack), 32'd0);
    for (int i = 0; i < 8; i++) begin
      m_dst_putn = 1'b0;
      chk("t1_eng_run", 32'(eng_rst), 32'd0);
      cyc();
    end
    m_dst_putn = 1'b1;
    chk("t1_beat_run", 32'(beat_cnt), 32'd8);
    m_endn = 1'b0;
    cyc();
    m_endn = 1'b1;
    chk("t1_clr_eng",  32'(eng_rst),  32'd1);
    chk("t1_clr_dc",   32'(dc),       32'd0);
    chk("t1_clr_done", 32'(ch0.done), 32'd0);
    cyc();
    chk("t1_done", 32'(ch0.done), 32'd1);
    chk("t1_err",  32'(ch0.err),  32'd0);
    chk("t1_beat", 32'(beat_cnt), 32'd8);
    cyc();
    chk("t1_idle_busy", 32'(busy),     32'd0);
    chk("t1_idle_done", 32'(ch0.done), 32'd0);

    // illegal descriptor on ch1
    ch1.req = 1'b1; ch1.dc = 24'h000000;
    cyc();
    chk("t2_ack",   32'(ch1.ack),  32'd1);
    chk("t2_done",  32'(ch1.done), 32'd1);
    chk("t2_err",   32'(ch1.err),  32'd1);
    chk("t2_eng",   32'(eng_rst),  32'd1);
    chk("t2_dc",    32'(dc),       32'd0);
    chk("t2_owner", 32'(owner),    32'd1);
    chk("t2_beat",  32'(beat_cnt), 32'd8);
    chk("t2_c0done",32'(ch0.done), 32'd0);
    ch1.req = 1'b0;
    cyc();
    chk("t2_idle_busy", 32'(busy),     32'd0);
    chk("t2_idle_done", 32'(ch1.done), 32'd0);

    // both requesting and held: ch0, ch1, ch0
    ch0.req = 1'b1; ch0.dc = 24'h000010;
    ch1.req = 1'b1; ch1.dc = 24'h5A5A3F;
    cyc();
    chk("t3a_owner", 32'(owner),   32'd0);
    chk("t3a_ack0",  32'(ch0.ack), 32'd1);
    chk("t3a_ack1",  32'(ch1.ack), 32'd0);
    chk("t3a_dc",    32'(dc),      32'h000010);
    cyc();
    end_op();
    chk("t3a_done", 32'(ch0.done), 32'd1);
    chk("t3a_wait", 32'(ch1.ack),  32'd0);
    cyc();
    chk("t3a_gap_busy", 32'(busy), 32'd0);
    cyc();
    chk("t3b_owner", 32'(owner),   32'd1);
    chk("t3b_ack1",  32'(ch1.ack), 32'd1);
    chk("t3b_dc",    32'(dc),      32'h5A5A3F);
    cyc();
    end_op();
    chk("t3b_done", 32'(ch1.done), 32'd1);
    chk("t3b_err",  32'(ch1.err),  32'd0);
    cyc();
    chk("t3b_gap_busy", 32'(busy), 32'd0);
    cyc();
    chk("t3c_owner", 32'(owner),   32'd0);
    chk("t3c_ack0",  32'(ch0.ack), 32'd1);
    ch0.req = 1'b0; ch1.req = 1'b0;
    cyc();
    end_op();
    chk("t3c_done", 32'(ch0.done), 32'd1);
    cyc();

    // 3 beats then stall: 16 no-beat RUN cycles, then CLEAR and error
    ch0.req = 1'b1; ch0.dc = 24'h000010;
    cyc();
    ch0.req = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      m_dst_putn = 1'b0;
      cyc();
    end
    m_dst_putn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_run_hold", 32'(eng_rst), 32'd0);
      cyc();
    end
    chk("t4_clr_eng",  32'(eng_rst),  32'd1);
    chk("t4_clr_done", 32'(ch0.done), 32'd0);
    cyc();
    chk("t4_done", 32'(ch0.done), 32'd1);
    chk("t4_err",  32'(ch0.err),  32'd1);
    chk("t4_beat", 32'(beat_cnt), 32'd3);
    cyc();

    // end arriving in the timeout cycle is a success
    ch1.req = 1'b1; ch1.dc = 24'h000010;
    cyc();
    chk("t5_owner", 32'(owner), 32'd1);
    ch1.req = 1'b0;
    cyc(16);
    chk("t5_last_run", 32'(eng_rst), 32'd0);
    end_op();
    chk("t5_done", 32'(ch1.done), 32'd1);
    chk("t5_err",  32'(ch1.err),  32'd0);
    chk("t5_beat", 32'(beat_cnt), 32'd0);
    cyc();

    // beat counter saturates at all-ones
    ch0.req = 1'b1; ch0.dc = 24'hFFFFFF;
    cyc();
    chk("t7_dc", 32'(dc), 32'hFFFFFF);
    ch0.req = 1'b0;
    cyc();
    for (int i = 0; i < 17; i++) begin
      m_dst_putn = 1'b0;
      cyc();
    end
    m_dst_putn = 1'b1;
    chk("t7_sat_run", 32'(beat_cnt), 32'd15);
    end_op();
    chk("t7_done", 32'(ch0.done), 32'd1);
    chk("t7_err",  32'(ch0.err),  32'd0);
    chk("t7_beat", 32'(beat_cnt), 32'd15);
    cyc();

    // reset mid-RUN after 5 beats
    ch1.req = 1'b1; ch1.dc = 24'h000010;
    cyc();
    chk("t6_owner", 32'(owner), 32'd1);
    ch1.req = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      m_dst_putn = 1'b0;
      cyc();
    end
    m_dst_putn = 1'b1;
    chk("t6_beat_pre", 32'(beat_cnt), 32'd5);
    #3 wb_rst_i = 1'b0;
    #1;
    chk("t6_dc",    32'(dc),       32'd0);
    chk("t6_eng",   32'(eng_rst),  32'd1);
    chk("t6_busy",  32'(busy),     32'd0);
    chk("t6_beat",  32'(beat_cnt), 32'd0);
    chk("t6_owner_rst", 32'(owner), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_done1", 32'(ch1.done), 32'd0);
      chk("t6_no_done0", 32'(ch0.done), 32'd0);
    end
    ch0.req = 1'b1; ch0.dc = 24'h000010;
    ch1.req = 1'b1; ch1.dc = 24'h000010;
    chk("t6_rst_hold_busy", 32'(busy), 32'd0);
    wb_rst_i = 1'b1;
    cyc();
    chk("t6_rr_owner", 32'(owner),   32'd0);
    chk("t6_rr_ack0",  32'(ch0.ack), 32'd1);
    chk("t6_rr_ack1",  32'(ch1.ack), 32'd0);
    ch0.req = 1'b0; ch1.req = 1'b0;
    cyc();
    end_op();
    chk("t6_post_done", 32'(ch0.done), 32'd1);
    cyc();
    chk("t6_post_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
